hdmi_video_timing: RTL
======================

HDMI_VIDEO_TIMING -- requirements
Module: hdmi_video_timing

Interface
REQ-001 Parameter: H_ACTIVE, 640, default visible pixels per line.
REQ-002 Parameter: H_FP/H_SYNC/H_BP, 16/96/48, default horizontal front porch/sync/back porch, in pixels.
REQ-003 Parameter: V_ACTIVE, 480, default visible lines per frame.
REQ-004 Parameter: V_FP/V_SYNC/V_BP, 10/2/33, default vertical front porch/sync/back porch, in lines.
REQ-005 Parameter: HS_POL/VS_POL, 0/0, default sync polarity (1 = active-high).
REQ-006 clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 cfg_valid  in  1  new timing set offered.
REQ-009 cfg_ready  out  1  block can accept a timing set.
REQ-010 cfg_h_active/fp/sync/bp, cfg_v_active/fp/sync/bp  in  12 each  offered timing fields.
REQ-011 cfg_hs_pol, cfg_vs_pol  in  1 each  offered polarities.
REQ-012 cfg_err  out  1  one-cycle pulse: offered set rejected.
REQ-013 px_x, px_y  out  12 each  stage-0 pixel coordinate to the pixel-colour stage.
REQ-014 data_en  out  1  stage-0 active-area flag to the pixel-colour stage.
REQ-015 hs, vs, de  out  1 each  stage-1 sync/enable to the HDMI transmitter.
REQ-016 frame_start, line_start  out  1 each  stage-0 one-cycle markers.

Function
REQ-017 h_cnt runs 0..h_total-1, with h_total = active+fp+sync+bp; v_cnt increments when h_cnt wraps, and runs 0..v_total-1.
REQ-018 Both counters wrap to 0 simultaneously at (h_total-1, v_total-1); 12-bit arithmetic throughout, so totals must be <= 4095.
REQ-019 Region order per line and per frame: active, front porch, sync, back porch.
REQ-020 data_en = (h_cnt < h_active) AND (v_cnt < v_active); it is registered and cycle-aligned with px_x/px_y.
REQ-021 px_x = h_cnt and px_y = v_cnt while data_en=1; both hold 0 while data_en=0.
REQ-022 Horizontal sync is asserted for h_active+h_fp <= h_cnt < h_active+h_fp+h_sync, on every line including blanking lines.
REQ-023 Vertical sync is asserted for whole lines v_active+v_fp <= v_cnt < v_active+v_fp+v_sync; its transitions coincide with h_cnt=0.
REQ-024 Asserted sync level = pol bit; deasserted level = inverse of the pol bit.
REQ-025 hs, vs, de = stage-0 hsync, vsync, data_en delayed by exactly 1 clk, matching the one-cycle registered pixel-colour latency.
REQ-026 frame_start=1 iff (h_cnt,v_cnt)=(0,0); line_start=1 iff h_cnt=0.
REQ-027 Config slots: one active set and one pending slot; cfg_ready=1 iff the pending slot is empty and rst=0.
REQ-028 Accept on cfg_valid AND cfg_ready.
REQ-029 A set is rejected if any active/sync field is 0, h_total > 4095 or v_total > 4095; on rejection, cfg_err pulses the next cycle and the pending slot is unchanged.
REQ-030 The pending set is copied to the active set on the cycle where the counters wrap (h_total-1, v_total-1), making it effective from frame_start; the pending slot then empties.
REQ-031 If an accept and the wrap occur in the same cycle, the accepted set becomes pending and applies at the next wrap, not the current one.
REQ-032 Timing never changes mid-frame; counters compare against the active set only.

Reset
REQ-033 While rst=1: active set = parameters, pending slot empty, h_cnt=H_total-1, v_cnt=V_total-1 held.
REQ-034 While rst=1: data_en=de=0, px_x=px_y=0, frame_start=line_start=cfg_err=cfg_ready=0, hs/vs at their deasserted levels.
REQ-035 The first rising edge with rst=0 yields (0,0): data_en=1, frame_start=1, line_start=1; de=1 one cycle later.
REQ-036 rst asserted mid-frame or mid-handshake discards the pending set; the next frame restarts per REQ-035.

Verification
REQ-037 Defaults, release rst -> data_en high 640 clocks per line; line period 800; hs low for h_cnt 656..751; frame period 420000 clocks; vs low on lines 490..491.
REQ-038 Stage-1 alignment -> de equals data_en delayed 1 clk on every cycle; hs/vs likewise.
REQ-039 Offer 1280/110/40/220, 720/5/5/20, pol 1/1 mid-frame -> accepted; current frame stays 800x525; next frame is 1650x750 with hs high on h_cnt 1390..1429.
REQ-040 Offer h_sync=0 -> cfg_err pulses 1 cycle, no timing change; second offer while pending is full -> cfg_ready=0, offer held, accepted after the wrap.
REQ-041 Accept on the exact wrap cycle -> applies one frame later (REQ-031).
REQ-042 Assert rst at h_cnt=300, v_cnt=200 with a set pending -> outputs per REQ-034; after release, default timing resumes from (0,0).

Source files
------------

// File: rtl/hdmi_video_timing.sv
// Raster timing generator: pixel/line counters, stage-0 pixel coordinate and markers,
// stage-1 sync/enable, plus a double-slot timing configuration that swaps only at frame wrap.
module hdmi_video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [11:0] cfg_h_active,
  input  logic [11:0] cfg_h_fp,
  input  logic [11:0] cfg_h_sync,
  input  logic [11:0] cfg_h_bp,
  input  logic [11:0] cfg_v_active,
  input  logic [11:0] cfg_v_fp,
  input  logic [11:0] cfg_v_sync,
  input  logic [11:0] cfg_v_bp,
  input  logic        cfg_hs_pol,
  input  logic        cfg_vs_pol,
  output logic        cfg_err,
  output logic [11:0] px_x,
  output logic [11:0] px_y,
  output logic        data_en,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        frame_start,
  output logic        line_start
);

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_active;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  localparam timing_t DEFAULT_SET = '{
    h_active: 12'(H_ACTIVE), h_fp: 12'(H_FP), h_sync: 12'(H_SYNC), h_bp: 12'(H_BP),
    v_active: 12'(V_ACTIVE), v_fp: 12'(V_FP), v_sync: 12'(V_SYNC), v_bp: 12'(V_BP),
    hs_pol: HS_POL, vs_pol: VS_POL
  };
  localparam logic [11:0] RST_H = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] RST_V = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  function automatic logic [11:0] h_total(input timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic logic [11:0] v_total(input timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  timing_t     act_q, act_d, pend_q, pend_d, offer;
  logic        pend_valid_q, pend_valid_d;
  logic        cfg_err_q, cfg_err_d;
  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [11:0] px_x_q, px_x_d, px_y_q, px_y_d;
  logic        data_en_q, data_en_d, hs0_q, hs0_d, vs0_q, vs0_d;
  logic        frame_start_q, frame_start_d, line_start_q, line_start_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [11:0] h_last, v_last, hs_start, hs_end, vs_start, vs_end;
  logic [13:0] offer_h_sum, offer_v_sum;
  logic        offer_ok, wrap;

  assign offer = '{
    h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
    v_active: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
    hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol
  };

  // Totals are checked at 14 bits so an oversized set cannot alias into 12-bit range.
  assign offer_h_sum = {2'b00, cfg_h_active} + {2'b00, cfg_h_fp} + {2'b00, cfg_h_sync} + {2'b00, cfg_h_bp};
  assign offer_v_sum = {2'b00, cfg_v_active} + {2'b00, cfg_v_fp} + {2'b00, cfg_v_sync} + {2'b00, cfg_v_bp};
  assign offer_ok = (cfg_h_active != 12'd0) && (cfg_h_sync != 12'd0) &&
                    (cfg_v_active != 12'd0) && (cfg_v_sync != 12'd0) &&
                    (offer_h_sum <= 14'd4095) && (offer_v_sum <= 14'd4095);

  assign h_last    = h_total(act_q) - 12'd1;
  assign v_last    = v_total(act_q) - 12'd1;
  assign wrap      = (h_cnt_q == h_last) && (v_cnt_q == v_last);
  assign cfg_ready = ~pend_valid_q & ~rst;

  always_comb begin
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    cfg_err_d    = 1'b0;
    h_cnt_d      = h_cnt_q + 12'd1;
    v_cnt_d      = v_cnt_q;
    if (h_cnt_q == h_last) begin
      h_cnt_d = 12'd0;
      v_cnt_d = (v_cnt_q == v_last) ? 12'd0 : v_cnt_q + 12'd1;
    end
    // A set accepted on the wrap cycle lands in the slot just vacated, so it waits a frame.
    if (wrap && pend_valid_q) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end
    if (cfg_valid && cfg_ready) begin
      if (offer_ok) begin
        pend_d       = offer;
        pend_valid_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
    if (rst) begin
      act_d        = DEFAULT_SET;
      pend_valid_d = 1'b0;
      cfg_err_d    = 1'b0;
      h_cnt_d      = RST_H;
      v_cnt_d      = RST_V;
    end

    // Stage-0 flags are decoded from the next position under the next active set.
    hs_start      = act_d.h_active + act_d.h_fp;
    hs_end        = hs_start + act_d.h_sync;
    vs_start      = act_d.v_active + act_d.v_fp;
    vs_end        = vs_start + act_d.v_sync;
    data_en_d     = (h_cnt_d < act_d.h_active) && (v_cnt_d < act_d.v_active);
    px_x_d        = data_en_d ? h_cnt_d : 12'd0;
    px_y_d        = data_en_d ? v_cnt_d : 12'd0;
    hs0_d         = ((h_cnt_d >= hs_start) && (h_cnt_d < hs_end)) ? act_d.hs_pol : ~act_d.hs_pol;
    vs0_d         = ((v_cnt_d >= vs_start) && (v_cnt_d < vs_end)) ? act_d.vs_pol : ~act_d.vs_pol;
    frame_start_d = (h_cnt_d == 12'd0) && (v_cnt_d == 12'd0);
    line_start_d  = (h_cnt_d == 12'd0);
    hs_d          = hs0_q;
    vs_d          = vs0_q;
    de_d          = data_en_q;
    if (rst) begin
      data_en_d     = 1'b0;
      px_x_d        = 12'd0;
      px_y_d        = 12'd0;
      hs0_d         = ~HS_POL;
      vs0_d         = ~VS_POL;
      frame_start_d = 1'b0;
      line_start_d  = 1'b0;
      hs_d          = ~HS_POL;
      vs_d          = ~VS_POL;
      de_d          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    act_q         <= act_d;
    pend_q        <= pend_d;
    pend_valid_q  <= pend_valid_d;
    cfg_err_q     <= cfg_err_d;
    h_cnt_q       <= h_cnt_d;
    v_cnt_q       <= v_cnt_d;
    px_x_q        <= px_x_d;
    px_y_q        <= px_y_d;
    data_en_q     <= data_en_d;
    hs0_q         <= hs0_d;
    vs0_q         <= vs0_d;
    frame_start_q <= frame_start_d;
    line_start_q  <= line_start_d;
    hs_q          <= hs_d;
    vs_q          <= vs_d;
    de_q          <= de_d;
  end

  assign cfg_err     = cfg_err_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign data_en     = data_en_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;

endmodule
